// File: rtl/dispatch_scheduler.sv
// Pops one item at a time from the queue head and hands it to the lowest-index free response team.
// Three-cycle IDLE/SERVE/ASSIGN sequence per dispatch; waits in IDLE while every team is busy.
module dispatch_scheduler #(
  parameter int NUM_TEAMS = 4,
  parameter int TW        = 8,
  parameter int BASE_TIME = 8,
  parameter int PRIO_STEP = 4,
  parameter int EVAC_TIME = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic                 head_valid,
  input  logic [7:0]           head_zone,
  input  logic [1:0]           head_priority,
  input  logic                 head_is_evac,
  input  logic [NUM_TEAMS-1:0] recall,
  output logic                 serve,
  output logic                 dispatch_valid,
  output logic [2:0]           dispatch_team,
  output logic [7:0]           dispatch_zone,
  output logic [1:0]           dispatch_priority,
  output logic [NUM_TEAMS-1:0] team_busy,
  output logic                 all_busy,
  output logic [15:0]          dispatch_count
);

  typedef enum logic [1:0] {IDLE, SERVE, ASSIGN} state_t;

  localparam int SW = TW + 3;

  state_t state_q, state_d;

  logic [NUM_TEAMS-1:0][TW-1:0] timer_q, timer_d;
  logic [NUM_TEAMS-1:0]         busy_q;
  logic [7:0]                   zone_q;
  logic [1:0]                   prio_q;
  logic                         evac_q;
  logic [2:0]                   last_team_q;
  logic [15:0]                  count_q;

  logic [2:0]    free_idx;
  logic [SW-1:0] svc_wide;
  logic [TW-1:0] svc_time;

  always_comb begin
    free_idx = 3'd0;
    for (int i = NUM_TEAMS - 1; i >= 0; i--) begin
      if (!busy_q[i]) free_idx = 3'(i);
    end
  end

  always_comb begin
    svc_wide = SW'(BASE_TIME) + SW'(PRIO_STEP) * SW'(prio_q);
    if (evac_q) begin
      svc_time = TW'(EVAC_TIME);
    end else if (svc_wide > SW'(2 ** TW - 1)) begin
      svc_time = '1;
    end else begin
      svc_time = svc_wide[TW-1:0];
    end
  end

  // Recall beats decrement, but a load into the team being assigned beats recall.
  always_comb begin
    for (int i = 0; i < NUM_TEAMS; i++) begin
      timer_d[i] = timer_q[i];
      if (recall[i]) begin
        timer_d[i] = '0;
      end else if (timer_q[i] != '0) begin
        timer_d[i] = timer_q[i] - 1'b1;
      end
      if (state_q == ASSIGN && free_idx == 3'(i)) begin
        timer_d[i] = svc_time;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (enable && head_valid && !all_busy) state_d = SERVE;
      SERVE:   state_d = head_valid ? ASSIGN : IDLE;
      ASSIGN:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      timer_q     <= '0;
      busy_q      <= '0;
      zone_q      <= '0;
      prio_q      <= '0;
      evac_q      <= 1'b0;
      last_team_q <= '0;
      count_q     <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      for (int i = 0; i < NUM_TEAMS; i++) begin
        busy_q[i] <= (timer_d[i] != '0);
      end
      // A head that vanished during SERVE is never captured, so dispatch outputs keep their last values.
      if (state_q == SERVE && head_valid) begin
        zone_q <= head_zone;
        prio_q <= head_priority;
        evac_q <= head_is_evac;
      end
      if (state_q == ASSIGN) begin
        last_team_q <= free_idx;
        if (count_q != 16'hFFFF) count_q <= count_q + 16'd1;
      end
    end
  end

  assign serve             = (state_q == SERVE);
  assign dispatch_valid    = (state_q == ASSIGN);
  assign dispatch_team     = (state_q == ASSIGN) ? free_idx : last_team_q;
  assign dispatch_zone     = zone_q;
  assign dispatch_priority = prio_q;
  assign team_busy         = busy_q;
  assign all_busy          = &busy_q;
  assign dispatch_count    = count_q;

endmodule

// File: tb/tb_dispatch_scheduler.sv
// Directed bench for dispatch_scheduler: a service-time vector table plus hand-written
// sequences for reset, team saturation, a vanishing head and recall.
module tb_dispatch_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic        head_valid;
  logic [7:0]  head_zone;
  logic [1:0]  head_priority;
  logic        head_is_evac;
  logic [3:0]  recall;
  logic        serve;
  logic        dispatch_valid;
  logic [2:0]  dispatch_team;
  logic [7:0]  dispatch_zone;
  logic [1:0]  dispatch_priority;
  logic [3:0]  team_busy;
  logic        all_busy;
  logic [15:0] dispatch_count;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [7:0] zone;
    logic [1:0] prio;
    logic       evac;
    int         svc;
  } vec_t;

  vec_t vecs[6];
  int   dcyc[$];
  int   dteam[$];
  int   exp_cyc[5]  = '{2, 5, 8, 11, 25};
  int   exp_team[5] = '{0, 1, 2, 3, 0};

  always #5 clk = ~clk;

  dispatch_scheduler dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .enable            (enable),
    .head_valid        (head_valid),
    .head_zone         (head_zone),
    .head_priority     (head_priority),
    .head_is_evac      (head_is_evac),
    .recall            (recall),
    .serve             (serve),
    .dispatch_valid    (dispatch_valid),
    .dispatch_team     (dispatch_team),
    .dispatch_zone     (dispatch_zone),
    .dispatch_priority (dispatch_priority),
    .team_busy         (team_busy),
    .all_busy          (all_busy),
    .dispatch_count    (dispatch_count)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench 1 ns after a rising edge with the DUT in IDLE: call this cycle 0.
  task automatic do_reset();
    rst_n         = 1'b0;
    enable        = 1'b0;
    head_valid    = 1'b0;
    head_zone     = 8'h00;
    head_priority = 2'd0;
    head_is_evac  = 1'b0;
    recall        = 4'b0000;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int   n;
    bit   serve_seen;
    vec_t v;

    vecs[0] = '{zone: 8'h2A, prio: 2'd2, evac: 1'b0, svc: 16};
    vecs[1] = '{zone: 8'h01, prio: 2'd0, evac: 1'b0, svc: 8};
    vecs[2] = '{zone: 8'h7F, prio: 2'd1, evac: 1'b0, svc: 12};
    vecs[3] = '{zone: 8'hC3, prio: 2'd3, evac: 1'b0, svc: 20};
    vecs[4] = '{zone: 8'h55, prio: 2'd3, evac: 1'b1, svc: 16};
    vecs[5] = '{zone: 8'hFF, prio: 2'd0, evac: 1'b1, svc: 16};

    // Reset values, then reset in the middle of SERVE and of ASSIGN
    do_reset();
    check("reset outputs",
          {serve, dispatch_valid, dispatch_team, dispatch_zone, dispatch_priority,
           team_busy, all_busy, dispatch_count}, 32'd0);
    enable = 1'b1; head_valid = 1'b1; head_zone = 8'h33; head_priority = 2'd1;
    tick();
    check("serve before reset", serve, 1);
    rst_n = 1'b0;
    #1;
    check("serve async drop", serve, 0);
    do_reset();
    enable = 1'b1; head_valid = 1'b1; head_zone = 8'h44; head_priority = 2'd2;
    tick();
    tick();
    check("assign before reset", dispatch_valid, 1);
    rst_n = 1'b0;
    #1;
    check("assign async drop", {dispatch_valid, dispatch_zone, dispatch_priority}, 0);
    check("count after reset", dispatch_count, 0);

    // Single dispatches from a fresh reset: outputs, latency and service time
    foreach (vecs[i]) begin
      v = vecs[i];
      do_reset();
      enable = 1'b1; head_valid = 1'b1;
      head_zone = v.zone; head_priority = v.prio; head_is_evac = v.evac;
      tick();
      check($sformatf("vec%0d serve cycle1", i), {serve, dispatch_valid}, 2'b10);
      tick();
      check($sformatf("vec%0d dispatch", i),
            {dispatch_valid, dispatch_team, dispatch_zone, dispatch_priority},
            {1'b1, 3'd0, v.zone, v.prio});
      enable = 1'b0; head_valid = 1'b0;
      n = 0;
      for (int k = 0; k < 300; k++) begin
        tick();
        if (team_busy[0]) n++;
        else break;
      end
      check($sformatf("vec%0d busy cycles", i), n, v.svc);
      check($sformatf("vec%0d count", i), {team_busy, dispatch_count}, {4'b0000, 16'd1});
    end

    // Continuous head: fill all four teams, stall, then reuse team 0.
    // Priority 3 gives 20-cycle jobs, long enough for all teams to be busy at once.
    do_reset();
    enable = 1'b1; head_valid = 1'b1; head_zone = 8'h10; head_priority = 2'd3;
    dcyc.delete();
    dteam.delete();
    serve_seen = 1'b0;
    for (int c = 1; c <= 27; c++) begin
      tick();
      if (dispatch_valid) begin
        dcyc.push_back(c);
        dteam.push_back(int'(dispatch_team));
      end
      if (c >= 12 && c <= 23 && serve) serve_seen = 1'b1;
      if (c == 12) check("sat all_busy", {all_busy, team_busy}, 5'b11111);
      if (c == 23) check("sat team0 free", {all_busy, team_busy}, 5'b01110);
    end
    check("sat dispatch total", dcyc.size(), 5);
    for (int i = 0; i < 5 && i < dcyc.size(); i++) begin
      check($sformatf("sat dispatch%0d cycle", i), dcyc[i], exp_cyc[i]);
      check($sformatf("sat dispatch%0d team", i), dteam[i], exp_team[i]);
    end
    check("sat no serve while full", serve_seen, 0);
    check("sat count", dispatch_count, 5);

    // head_valid vanishes during SERVE: no dispatch, nothing changes
    do_reset();
    enable = 1'b1; head_valid = 1'b1; head_zone = 8'hA1; head_priority = 2'd3;
    repeat (4) tick();
    check("drop serve again", {serve, team_busy}, {1'b1, 4'b0001});
    head_valid = 1'b0; head_zone = 8'hB2; head_priority = 2'd1;
    n = 0;
    for (int c = 5; c <= 6; c++) begin
      tick();
      if (dispatch_valid || serve) n++;
    end
    check("drop no dispatch", n, 0);
    check("drop state kept",
          {dispatch_count, team_busy, dispatch_zone, dispatch_priority},
          {16'd1, 4'b0001, 8'hA1, 2'd3});
    head_valid = 1'b1;
    tick();
    tick();
    check("drop next dispatch", {dispatch_valid, dispatch_team, dispatch_zone},
          {1'b1, 3'd1, 8'hB2});

    // Recall: free team 1, reuse it, and confirm a load beats a same-cycle recall
    do_reset();
    enable = 1'b1; head_valid = 1'b1; head_zone = 8'h20; head_priority = 2'd3;
    repeat (8) tick();
    check("recall setup dispatch", {dispatch_valid, dispatch_team}, {1'b1, 3'd2});
    head_valid = 1'b0;
    tick();
    check("recall busy before", team_busy, 4'b0111);
    recall = 4'b1010;
    tick();
    recall = 4'b0000;
    check("recall team1 freed", team_busy, 4'b0101);
    head_valid = 1'b1; head_zone = 8'h21;
    tick();
    check("recall serve", serve, 1);
    tick();
    check("recall reuse team1", {dispatch_valid, dispatch_team, dispatch_zone},
          {1'b1, 3'd1, 8'h21});
    head_valid = 1'b0;
    recall = 4'b0010;
    tick();
    recall = 4'b0000;
    check("load beats recall", team_busy, 4'b0111);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
